// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD counter slice.
// Decade digit type, limits and nibble validity check.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_valid(
    input bcd_digit_t nib
  );
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: reset, sanitised load, up/down step.
// at_lim flags 9 when counting up, 0 when counting down.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       ck,
  input  logic       rst,
  input  bcd_digit_t rst_val,
  input  logic       step,
  input  logic       up_dn,
  input  logic       ld,
  input  bcd_digit_t ld_val,
  output bcd_digit_t d,
  output logic       at_lim
);

  bcd_digit_t d_q;
  bcd_digit_t d_d;

  // Next digit: load beats step; an invalid nibble loads as 0.
  always_comb begin
    d_d = d_q;
    if (ld) begin
      if (bcd_valid(ld_val)) begin
        d_d = ld_val;
      end else begin
        d_d = BCD_MIN;
      end
    end else if (step) begin
      if (up_dn) begin
        if (d_q == BCD_MAX) begin
          d_d = BCD_MIN;
        end else begin
          d_d = d_q + 4'd1;
        end
      end else begin
        if (d_q == BCD_MIN) begin
          d_d = BCD_MAX;
        end else begin
          d_d = d_q - 4'd1;
        end
      end
    end
  end

  // Digit register with synchronous reset.
  always_ff @(posedge ck) begin
    if (rst) begin
      d_q <= rst_val;
    end else begin
      d_q <= d_d;
    end
  end

  assign d = d_q;
  assign at_lim = up_dn ? (d_q == BCD_MAX)
                        : (d_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-decade up/down BCD counter with load and tc.
// Define BCD_SAT_EN to saturate at the ends instead of wrapping.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 2,
  parameter logic [4*NUM_DIGITS-1:0] RST_VAL = '0
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    up_dn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] q,
  output logic                    tc,
  output logic                    load_err
);

  logic [NUM_DIGITS-1:0] at_lim;
  logic [NUM_DIGITS-1:0] step;
  logic [NUM_DIGITS:0]   run;
  logic                  all_lim;
  logic                  hold;
  logic                  load_err_q;
  logic                  load_err_d;

  assign run[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig
      assign run[gi+1] = run[gi] & at_lim[gi];
      assign step[gi]  = en & run[gi] & ~hold;

      bcd_digit u_dig (
        .ck      (ck),
        .rst     (rst),
        .rst_val (RST_VAL[4*gi +: 4]),
        .step    (step[gi]),
        .up_dn   (up_dn),
        .ld      (load),
        .ld_val  (load_val[4*gi +: 4]),
        .d       (q[4*gi +: 4]),
        .at_lim  (at_lim[gi])
      );
    end
  endgenerate

  assign all_lim = run[NUM_DIGITS];

`ifdef BCD_SAT_EN
  assign hold = all_lim;
`else
  assign hold = 1'b0;
`endif

  assign tc = en & ~load & all_lim;

  // Flag a load that carried any nibble above 9.
  always_comb begin
    load_err_d = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!bcd_valid(load_val[4*i +: 4])) begin
        load_err_d = load;
      end
    end
  end

  // load_err lasts one cycle after the offending load.
  always_ff @(posedge ck) begin
    if (rst) begin
      load_err_q <= 1'b0;
    end else begin
      load_err_q <= load_err_d;
    end
  end

  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n, two decades.
// A decimal model pushes expected state; DUT output is popped.
module tb_bcd_counter_n;

  logic       ck = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] q;
  logic       tc;
  logic       load_err;
  logic [7:0] q35;
  logic       tc35;
  logic       le35;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [7:0] m_q;
  logic       m_ok = 1'b0;

  always #5 ck = ~ck;

  bcd_counter_n #(
    .NUM_DIGITS (2),
    .RST_VAL    (8'h00)
  ) dut (
    .ck       (ck),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .load_err (load_err)
  );

  bcd_counter_n #(
    .NUM_DIGITS (2),
    .RST_VAL    (8'h35)
  ) dut35 (
    .ck       (ck),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .q        (q35),
    .tc       (tc35),
    .load_err (le35)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic int to_int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic logic [3:0] san(input logic [3:0] n);
    return (n > 4'd9) ? 4'd0 : n;
  endfunction

  task automatic cyc(
    input logic r,
    input logic l,
    input logic [7:0] lv,
    input logic e,
    input logic u
  );
    logic [8:0] got;
    logic [8:0] want;
    logic [7:0] nq;
    logic       nle;
    logic       mtc;
    int         v;
    rst = r;
    load = l;
    load_val = lv;
    en = e;
    up_dn = u;
    #1;
    if (m_ok) begin
      mtc = e & ~l & (u ? (m_q == 8'h99)
                        : (m_q == 8'h00));
      chk("tc", {31'd0, tc}, {31'd0, mtc});
    end
    nle = 1'b0;
    nq = m_q;
    if (r) begin
      nq = 8'h00;
    end else if (l) begin
      nq = {san(lv[7:4]), san(lv[3:0])};
      nle = (lv[7:4] > 4'd9) | (lv[3:0] > 4'd9);
    end else if (e) begin
      v = to_int(m_q);
`ifdef BCD_SAT_EN
      if (u) v = (v == 99) ? 99 : v + 1;
      else   v = (v == 0) ? 0 : v - 1;
`else
      if (u) v = (v + 1) % 100;
      else   v = (v + 99) % 100;
`endif
      nq = to_bcd(v);
    end
    exp_q.push_back({nle, nq});
    @(posedge ck);
    #1;
    if (r || m_ok) begin
      got = {load_err, q};
      want = exp_q.pop_front();
      chk("q", {24'd0, got[7:0]}, {24'd0, want[7:0]});
      chk("lerr", {31'd0, got[8]}, {31'd0, want[8]});
      m_q = want[7:0];
      m_ok = 1'b1;
    end else begin
      void'(exp_q.pop_front());
    end
    if (r) begin
      chk("q35", {24'd0, q35}, 32'h35);
      chk("le35", {31'd0, le35}, 32'd0);
    end
  endtask

  initial begin
    @(posedge ck);
    #1;
    cyc(1, 0, 8'h00, 1, 1);
    cyc(1, 0, 8'h00, 1, 1);
    for (int i = 0; i < 101; i++) begin
      cyc(0, 0, 8'h00, 1, 1);
    end
    cyc(1, 0, 8'h00, 0, 1);
    for (int i = 0; i < 101; i++) begin
      cyc(0, 0, 8'h00, 1, 0);
    end
    cyc(0, 1, 8'h47, 1, 1);
    cyc(0, 1, 8'h4C, 1, 1);
    cyc(0, 0, 8'h00, 0, 1);
    cyc(0, 1, 8'hC3, 1, 0);
    cyc(0, 1, 8'h50, 0, 1);
    for (int i = 0; i < 7; i++) begin
      cyc(0, 0, 8'h00, 1, 1);
    end
    chk("q57", {24'd0, q}, 32'h57);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 8'h00, 0, 1);
    end
    cyc(1, 1, 8'h77, 1, 1);
    cyc(0, 1, 8'h99, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 8'h00, 1, 1);
    end
    cyc(0, 0, 8'h00, 1, 0);
    cyc(0, 0, 8'h00, 1, 1);
    cyc(0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 31) == 0),
          ($urandom_range(0, 7) == 0),
          8'($urandom),
          ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) < 12));
    end
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
